// File: rtl/core_rd_arbiter.sv
// Shared AXI4-Lite read port arbiter for instruction fetch and data loads.
// One outstanding transaction; R beats are returned to the granted side only.
module core_rd_arbiter #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic [AXI_AWIDTH-1:0] IM_ARADDR,
  input  logic                  IM_ARVALID,
  output logic                  IM_ARREADY,
  output logic [AXI_DWIDTH-1:0] IM_RDATA,
  output logic [1:0]            IM_RRESP,
  output logic                  IM_RVALID,
  input  logic                  IM_RREADY,
  input  logic [AXI_AWIDTH-1:0] DM_ARADDR,
  input  logic                  DM_ARVALID,
  output logic                  DM_ARREADY,
  output logic [AXI_DWIDTH-1:0] DM_RDATA,
  output logic [1:0]            DM_RRESP,
  output logic                  DM_RVALID,
  input  logic                  DM_RREADY,
  output logic [AXI_AWIDTH-1:0] M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [AXI_DWIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_gnt_dm;
  logic                  r_last_dm;
  logic [AXI_AWIDTH-1:0] r_araddr;
  logic                  w_go;
  logic                  w_pick_dm;
  logic                  w_r_done;

  // NRST gates the request so no ARREADY can leak out while held in reset
  assign w_go = NRST && (IM_ARVALID || DM_ARVALID);

  always_comb begin
    w_pick_dm = DM_ARVALID;
    if (IM_ARVALID && DM_ARVALID) begin
      w_pick_dm = (FIXED_PRIO != 0) ? 1'b1 : !r_last_dm;
    end
  end

  assign w_r_done = (r_state == S_DATA) && M_RVALID && M_RREADY;
  assign M_ARADDR = r_araddr;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state   <= S_IDLE;
      r_gnt_dm  <= 1'b0;
      r_last_dm <= 1'b1;
      r_araddr  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_go) begin
        r_gnt_dm <= w_pick_dm;
        r_araddr <= w_pick_dm ? DM_ARADDR : IM_ARADDR;
      end
      if (w_r_done) begin
        r_last_dm <= r_gnt_dm;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    IM_ARREADY = 1'b0;
    DM_ARREADY = 1'b0;
    M_ARVALID  = 1'b0;
    M_RREADY   = 1'b0;
    IM_RDATA   = '0;
    IM_RRESP   = 2'b00;
    IM_RVALID  = 1'b0;
    DM_RDATA   = '0;
    DM_RRESP   = 2'b00;
    DM_RVALID  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_next     = S_ADDR;
          IM_ARREADY = !w_pick_dm;
          DM_ARREADY = w_pick_dm;
        end
      end
      S_ADDR: begin
        M_ARVALID = 1'b1;
        if (M_ARREADY) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (r_gnt_dm) begin
          DM_RDATA  = M_RDATA;
          DM_RRESP  = M_RRESP;
          DM_RVALID = M_RVALID;
          M_RREADY  = DM_RREADY;
        end else begin
          IM_RDATA  = M_RDATA;
          IM_RRESP  = M_RRESP;
          IM_RVALID = M_RVALID;
          M_RREADY  = IM_RREADY;
        end
        if (M_RVALID && M_RREADY) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_rd_arbiter.sv
// Directed bench for core_rd_arbiter: round-robin and fixed-priority
// instances, each with a small behavioural memory responder.
module tb_core_rd_arbiter;

  logic CLK = 1'b0;
  logic NRST = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] im_araddr, dm_araddr;
  logic        im_arvalid, dm_arvalid, im_rready, dm_rready;

  logic        im_arready[2], im_rvalid[2], dm_arready[2], dm_rvalid[2];
  logic        m_arvalid[2], m_rready[2];
  logic [31:0] im_rdata[2], dm_rdata[2], m_araddr[2];
  logic [1:0]  im_rresp[2], dm_rresp[2];
  logic        m_arready[2], m_rvalid[2];
  logic [31:0] m_rdata[2];
  logic [1:0]  m_rresp[2];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ar_wait, r_wait;
  logic [1:0]  rresp_cfg;
  bit          oneshot;

  bit          ar_hs[2], r_hs[2], im_g[2], dm_g[2];
  int          im_done[2], dm_done[2];
  logic [31:0] last_im_rdata[2];
  logic [1:0]  last_dm_rresp[2];
  logic [31:0] lat_addr[2];
  int          phase[2], cnt[2];
  int          gq0[$], gq1[$];
  logic [31:0] aq0[$], aq1[$];

  core_rd_arbiter #(.FIXED_PRIO(0)) u_rr (
    .CLK(CLK), .NRST(NRST),
    .IM_ARADDR(im_araddr), .IM_ARVALID(im_arvalid),
    .IM_ARREADY(im_arready[0]), .IM_RDATA(im_rdata[0]),
    .IM_RRESP(im_rresp[0]), .IM_RVALID(im_rvalid[0]),
    .IM_RREADY(im_rready),
    .DM_ARADDR(dm_araddr), .DM_ARVALID(dm_arvalid),
    .DM_ARREADY(dm_arready[0]), .DM_RDATA(dm_rdata[0]),
    .DM_RRESP(dm_rresp[0]), .DM_RVALID(dm_rvalid[0]),
    .DM_RREADY(dm_rready),
    .M_ARADDR(m_araddr[0]), .M_ARVALID(m_arvalid[0]),
    .M_ARREADY(m_arready[0]), .M_RDATA(m_rdata[0]),
    .M_RRESP(m_rresp[0]), .M_RVALID(m_rvalid[0]),
    .M_RREADY(m_rready[0])
  );

  core_rd_arbiter #(.FIXED_PRIO(1)) u_fx (
    .CLK(CLK), .NRST(NRST),
    .IM_ARADDR(im_araddr), .IM_ARVALID(im_arvalid),
    .IM_ARREADY(im_arready[1]), .IM_RDATA(im_rdata[1]),
    .IM_RRESP(im_rresp[1]), .IM_RVALID(im_rvalid[1]),
    .IM_RREADY(im_rready),
    .DM_ARADDR(dm_araddr), .DM_ARVALID(dm_arvalid),
    .DM_ARREADY(dm_arready[1]), .DM_RDATA(dm_rdata[1]),
    .DM_RRESP(dm_rresp[1]), .DM_RVALID(dm_rvalid[1]),
    .DM_RREADY(dm_rready),
    .M_ARADDR(m_araddr[1]), .M_ARVALID(m_arvalid[1]),
    .M_ARREADY(m_arready[1]), .M_RDATA(m_rdata[1]),
    .M_RRESP(m_rresp[1]), .M_RVALID(m_rvalid[1]),
    .M_RREADY(m_rready[1])
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : (a ^ 32'hDEAD0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Sample handshakes at the active edge, before the DUT state updates
  always @(posedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (NRST) begin
        ar_hs[d] = m_arvalid[d] && m_arready[d];
        r_hs[d]  = m_rvalid[d] && m_rready[d];
        im_g[d]  = im_arready[d];
        dm_g[d]  = dm_arready[d];
        if (ar_hs[d]) lat_addr[d] = m_araddr[d];
        if (d == 0) begin
          if (im_arready[d]) gq0.push_back(0);
          if (dm_arready[d]) gq0.push_back(1);
          if (ar_hs[d]) aq0.push_back(m_araddr[d]);
        end else begin
          if (im_arready[d]) gq1.push_back(0);
          if (dm_arready[d]) gq1.push_back(1);
          if (ar_hs[d]) aq1.push_back(m_araddr[d]);
        end
        if (im_rvalid[d] && im_rready) begin
          im_done[d]++;
          last_im_rdata[d] = im_rdata[d];
        end
        if (dm_rvalid[d] && dm_rready) begin
          dm_done[d]++;
          last_dm_rresp[d] = dm_rresp[d];
        end
      end else begin
        ar_hs[d] = 0;
        r_hs[d]  = 0;
        im_g[d]  = 0;
        dm_g[d]  = 0;
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      phase[d] = 0; cnt[d] = 0; lat_addr[d] = '0;
      m_arready[d] = 0; m_rvalid[d] = 0;
      m_rdata[d] = '0; m_rresp[d] = '0;
    end
    forever begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        if (!NRST) begin
          phase[d] = 0; cnt[d] = 0;
          m_arready[d] = 0; m_rvalid[d] = 0;
          m_rdata[d] = '0; m_rresp[d] = '0;
        end else begin
          case (phase[d])
            0: begin
              if (ar_hs[d]) begin
                m_arready[d] = 0; phase[d] = 1; cnt[d] = 0;
              end else if (m_arvalid[d]) begin
                if (cnt[d] >= ar_wait) m_arready[d] = 1;
                else cnt[d]++;
              end
            end
            1: begin
              if (cnt[d] >= r_wait) begin
                m_rvalid[d] = 1;
                m_rdata[d]  = mdata(lat_addr[d]);
                m_rresp[d]  = rresp_cfg;
                phase[d]    = 2;
              end else cnt[d]++;
            end
            default: begin
              if (r_hs[d]) begin
                m_rvalid[d] = 0; m_rdata[d] = '0; m_rresp[d] = '0;
                phase[d] = 0; cnt[d] = 0;
              end
            end
          endcase
        end
      end
      if (oneshot) begin
        if (im_g[0]) im_arvalid = 0;
        if (dm_g[0]) dm_arvalid = 0;
      end
    end
  end

  task automatic do_reset();
    NRST = 0;
    im_arvalid = 0; dm_arvalid = 0;
    im_araddr = '0; dm_araddr = '0;
    im_rready = 1; dm_rready = 1;
    oneshot = 1; ar_wait = 0; r_wait = 0; rresp_cfg = 2'b00;
    repeat (2) @(posedge CLK);
    gq0.delete(); gq1.delete(); aq0.delete(); aq1.delete();
    for (int d = 0; d < 2; d++) begin
      im_done[d] = 0; dm_done[d] = 0;
      last_im_rdata[d] = '0; last_dm_rresp[d] = '0;
    end
    tick();
    NRST = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bit bad;
    do_reset();
    NRST = 0;
    im_arvalid = 1; dm_arvalid = 1;
    im_araddr = 32'h44; dm_araddr = 32'h88;
    #3;
    chk("rst_im_arready", im_arready[0], 0);
    chk("rst_dm_arready", dm_arready[0], 0);
    chk("rst_m_arvalid", m_arvalid[0], 0);
    chk("rst_m_araddr", m_araddr[0], 0);
    chk("rst_m_rready", m_rready[0], 0);
    chk("rst_im_rvalid", im_rvalid[0], 0);

    do_reset();
    im_araddr = 32'h100; im_arvalid = 1; r_wait = 2;
    #1;
    chk("t1_arready", im_arready[0], 1);
    chk("t1_dm_arready", dm_arready[0], 0);
    tick();
    chk("t1_m_arvalid", m_arvalid[0], 1);
    chk("t1_m_araddr", m_araddr[0], 32'h100);
    chk("t1_pulse", im_arready[0], 0);
    bad = 0;
    for (int i = 0; i < 20 && im_done[0] == 0; i++) begin
      if (dm_rvalid[0]) bad = 1;
      tick();
    end
    chk("t1_done", im_done[0], 1);
    chk("t1_rdata", last_im_rdata[0], 32'h13);
    chk("t1_dm_rvalid", bad, 0);
    chk("t1_idle", m_arvalid[0], 0);

    do_reset();
    im_araddr = 32'h0; dm_araddr = 32'h2000;
    im_arvalid = 1; dm_arvalid = 1;
    for (int i = 0; i < 40 && (im_done[0] + dm_done[0]) < 2; i++) tick();
    chk("t2_done", im_done[0] + dm_done[0], 2);
    chk("t2_ngrant", gq0.size(), 2);
    if (gq0.size() >= 2 && aq0.size() >= 2) begin
      chk("t2_g0", gq0[0], 0);
      chk("t2_g1", gq0[1], 1);
      chk("t2_a0", aq0[0], 32'h0);
      chk("t2_a1", aq0[1], 32'h2000);
    end

    do_reset();
    oneshot = 0;
    im_araddr = 32'h40; dm_araddr = 32'h80;
    im_arvalid = 1; dm_arvalid = 1;
    for (int i = 0; i < 200 && (gq0.size() < 6 || gq1.size() < 6); i++)
      tick();
    im_arvalid = 0; dm_arvalid = 0;
    chk("t3_n_rr", gq0.size() >= 6, 1);
    chk("t3_n_fx", gq1.size() >= 6, 1);
    if (gq0.size() >= 6 && gq1.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("t3_rr%0d", k), gq0[k], k % 2);
        chk($sformatf("t3_fx%0d", k), gq1[k], 1);
      end
    end

    do_reset();
    ar_wait = 5; im_rready = 0;
    im_araddr = 32'h300; im_arvalid = 1;
    tick();
    bad = 0;
    for (int i = 0; i < 30 && !m_rvalid[0]; i++) begin
      if (m_arvalid[0] && m_araddr[0] != 32'h300) bad = 1;
      tick();
    end
    chk("t4_stable", bad, 0);
    chk("t4_rvalid", m_rvalid[0], 1);
    for (int k = 0; k < 3; k++) begin
      chk("t4_m_rready", m_rready[0], 0);
      chk("t4_hold_v", im_rvalid[0], 1);
      chk("t4_hold_d", im_rdata[0], mdata(32'h300));
      tick();
    end
    im_rready = 1;
    #1;
    chk("t4_fwd_rready", m_rready[0], 1);
    for (int i = 0; i < 10 && im_done[0] == 0; i++) tick();
    repeat (3) tick();
    chk("t4_single", im_done[0], 1);
    chk("t4_after", im_rvalid[0], 0);

    do_reset();
    rresp_cfg = 2'b10;
    dm_araddr = 32'h500; dm_arvalid = 1;
    for (int i = 0; i < 20 && dm_done[0] == 0; i++) tick();
    chk("t5_done", dm_done[0], 1);
    chk("t5_rresp", last_dm_rresp[0], 2'b10);
    chk("t5_dm_rvalid", dm_rvalid[0], 0);
    chk("t5_m_arvalid", m_arvalid[0], 0);
    im_araddr = 32'h600; im_arvalid = 1;
    #1;
    chk("t5_idle_grant", im_arready[0], 1);

    do_reset();
    r_wait = 3;
    dm_araddr = 32'h700; dm_arvalid = 1;
    tick();
    im_araddr = 32'h800; im_arvalid = 1;
    #1;
    chk("t6_wait", im_arready[0], 0);
    for (int i = 0; i < 20 && !m_rready[0]; i++) tick();
    chk("t6_data", m_rready[0], 1);
    NRST = 0;
    #1;
    chk("t6_m_rready", m_rready[0], 0);
    chk("t6_m_arvalid", m_arvalid[0], 0);
    chk("t6_m_araddr", m_araddr[0], 0);
    chk("t6_im_arready", im_arready[0], 0);
    chk("t6_dm_rvalid", dm_rvalid[0], 0);
    chk("t6_dm_rdata", dm_rdata[0], 0);
    repeat (2) tick();
    NRST = 1;
    #1;
    chk("t6_im_first", im_arready[0], 1);
    for (int i = 0; i < 30 && im_done[0] == 0; i++) tick();
    repeat (3) tick();
    chk("t6_im_done", im_done[0], 1);
    chk("t6_no_replay", dm_done[0], 0);
    if (aq0.size() > 0) chk("t6_addr", aq0[aq0.size()-1], 32'h800);
    else chk("t6_addr_n", aq0.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
